fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Master (initiator) side of the ram_bus code-memory interface. Walks a fetch PC,
//  drives word addresses to the code RAM, captures returned words after the RAM's
//  fixed 1-cycle read latency and buffers them in a small FIFO with valid/ready
//  hand-off to the core decoder. Stops after fetching the halt word.
//  Restarts on a redirect (branch/jump) or on reset.
// PARAMETERS
//  WIDTH      16      instruction/data word width (matches ram_bus)
//  ADDR_W     16      word-address width; PC wraps modulo 2**ADDR_W
//  DEPTH      4       prefetch FIFO entries (power of two, >=2)
//  RESET_PC   0       PC loaded on reset
//  HALT_WORD  16'h0002  encoding of hlt; fetch stops after delivering it
// PORTS
//  clock           in   1       rising-edge clock, shared with code RAM
//  reset           in   1       synchronous, active-high
//  running         in   1       core_control run enable; 0 = issue no new fetches
//  bus_addr        out  ADDR_W  ram_bus address; RAM samples it at posedge clock
//  bus_read        in   WIDTH   ram_bus read data, = mem[addr sampled at previous edge]
//  redirect_valid  in   1       load new PC, flush all buffered/in-flight words
//  redirect_pc     in   ADDR_W  target PC for redirect
//  instr_valid     out  1       FIFO head valid
//  instr_ready     in   1       decoder accepts head when valid&ready at posedge
//  instr_data      out  WIDTH   FIFO head word
//  instr_pc        out  ADDR_W  address the head word was fetched from
//  halted          out  1       HALT_WORD has been enqueued; fetch stopped
// BEHAVIOUR
//  - Reset: pc=bus_addr=RESET_PC, FIFO empty, instr_valid=0, instr_data=0,
//    instr_pc=0, halted=0, no fetch in flight, state FETCH.
//  - bus_addr is the registered pc (glitch-free, stable across each edge).
//  - Issue at an edge iff state==FETCH & running & !redirect_valid &
//    (count + inflight) < DEPTH, count/inflight being registered values.
//    On issue: inflight<=1, inflight_pc<=pc, pc<=pc+1 (wraps). At most 1 in flight.
//  - Return: at the edge after an issue, if inflight and not squashed,
//    {bus_read, inflight_pc} is pushed. Slot was reserved at issue: push never
//    overflows, never dropped by backpressure.
//  - Pop: at edge with instr_valid & instr_ready; push and pop same edge allowed,
//    count unchanged. Order strictly preserved. FIFO head delivered with 0 extra
//    latency; first instr_valid 2 edges after first issue.
//  - States: FETCH -> HALTED when a pushed word == HALT_WORD (that word still
//    enqueued). Fetch issued on the same edge is squashed; in HALTED, returns are
//    discarded, no issue, halted=1, queued words still drain.
//    HALTED -> FETCH only on redirect or reset.
//  - Redirect (priority over push, pop, issue): FIFO flushed, in-flight squashed,
//    pc<=redirect_pc, halted<=0, state FETCH; a same-edge pop handshake is void.
//    First issue from redirect_pc on the following edge.
//  - running=0: no new issue; an in-flight word still completes and is pushed.
//  - Reset mid-operation: identical to power-on reset, in-flight return ignored.
// TESTING
//  - RAM words 0-7 = 0a00,0b00,0c00,0d00,0e00,0f00,4c67,0002, ready=1, running=1
//    -> 8 words out, pcs 0..7 in order, halted=1 after pc 7, bus_addr frozen.
//  - Same image, instr_ready=0 for 10 cycles -> count reaches 4, no issue once
//    count+inflight==4, bus_addr stays 4; release -> pcs 0..7 delivered, none lost.
//  - Redirect to 0x20 while FIFO holds 2 words and 1 in flight -> instr_valid=0
//    next cycle, next delivered instr_pc=0x20, stale words never appear.
//  - Drop running for 3 cycles mid-stream -> in-flight word still delivered,
//    bus_addr constant, no new pushes; resume continues at next PC.
//  - ADDR_W=4, redirect to 14 -> delivered pcs 14,15,0,1 (wrap).
//  - Assert reset with FIFO full and halted=1 -> next cycle instr_valid=0,
//    halted=0, bus_addr=RESET_PC; fetch restarts from RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: code-memory fetch master with prefetch FIFO and valid/ready hand-off
module fetch_unit #(
  parameter int WIDTH = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] HALT_WORD = 'h0002
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              running,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic [WIDTH-1:0]  bus_read,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WIDTH-1:0]  instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {FETCH, HALTED} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc, inflight_pc;
  logic inflight;
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic issue, push, pop, hit_halt;
  assign bus_addr = pc;
  assign instr_valid = count != '0;
  assign instr_data = instr_valid ? data_mem[rd_ptr] : '0;
  assign instr_pc = instr_valid ? pc_mem[rd_ptr] : '0;
  assign halted = state_q == HALTED;
  // issue/return/pop decisions; a slot is reserved at issue so a return always fits
  always_comb begin
    issue = state_q == FETCH && running && !redirect_valid && (count + CW'(inflight)) < CW'(DEPTH);
    push = inflight && state_q == FETCH && !redirect_valid;
    pop = instr_valid && instr_ready && !redirect_valid;
    hit_halt = push && bus_read == HALT_WORD;
    state_d = redirect_valid ? FETCH : hit_halt ? HALTED : state_q;
  end
  // state register
  always_ff @(posedge clock) state_q <= reset ? FETCH : state_d;
  // pc walk, in-flight tracking and FIFO pointers; redirect flushes everything
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (issue) pc <= pc + 1'b1;
      if (issue) inflight_pc <= pc;
      inflight <= issue && !hit_halt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // FIFO storage: returned word together with the address it came from
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      data_mem[wr_ptr] <= bus_read;
      pc_mem[wr_ptr] <= inflight_pc;
    end
  end
endmodule
